// File: rtl/seg_scan.sv
// Eight-digit multiplexed seven-segment driver: hex or unsigned-decimal display of a 16-bit
// word, with a sequential double-dabble converter feeding the decimal digits.
module seg_scan #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] seg_data,
    input  logic        disp_mode,
    input  logic        blank_lz,
    output logic [7:0]  seg_en,
    output logic [7:0]  seg_out,
    output logic        busy
);

    localparam int              PW      = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]   PS_LAST = PW'(SCAN_DIV - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // ------------------------------------------------------------------
    // Digit-slot prescaler and scan index
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_reg;
    logic          tick;
    logic [2:0]    idx_reg;
    logic [2:0]    idx_next;

    assign tick     = (presc_reg == PS_LAST);
    assign idx_next = idx_reg + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg <= '0;
            idx_reg   <= 3'd0;
        end else begin
            presc_reg <= tick ? '0 : presc_reg + 1'b1;
            if (tick) begin
                idx_reg <= idx_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Double-dabble binary-to-BCD engine
    // ------------------------------------------------------------------
    logic [1:0]  state_reg;
    logic [15:0] shreg_reg;
    logic [19:0] bcd_w_reg;
    logic [3:0]  cnt_reg;
    logic        busy_reg;
    logic [19:0] bcd_q_reg;
    logic [15:0] last_src_reg;
    logic [19:0] bcd_adj;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_w_reg[gi*4 +: 4] >= 4'd5)
                                      ? bcd_w_reg[gi*4 +: 4] + 4'd3
                                      : bcd_w_reg[gi*4 +: 4];
        end
    endgenerate

    // bcd_q only moves in DONE, so the display never sees a half-converted value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            shreg_reg    <= 16'h0;
            bcd_w_reg    <= 20'h0;
            cnt_reg      <= 4'd0;
            busy_reg     <= 1'b0;
            bcd_q_reg    <= 20'h0;
            last_src_reg <= 16'h0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (seg_data != last_src_reg) begin
                        state_reg <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    shreg_reg    <= seg_data;
                    last_src_reg <= seg_data;
                    bcd_w_reg    <= 20'h0;
                    cnt_reg      <= 4'd0;
                    busy_reg     <= 1'b1;
                    state_reg    <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    {bcd_w_reg, shreg_reg} <= {bcd_adj, shreg_reg} << 1;
                    cnt_reg <= cnt_reg + 4'd1;
                    if (cnt_reg == 4'd15) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bcd_q_reg <= bcd_w_reg;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Digit content, leading-zero blanking and segment decode
    // ------------------------------------------------------------------
    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [3:0] nib [8];
    logic [7:0] shown;
    logic [7:0] nz_from;
    logic [7:0] lit;

    generate
        for (gi = 0; gi < 8; gi++) begin : g_digit
            localparam bit HEX_SHOWN = (gi < 4);
            localparam bit DEC_SHOWN = (gi < 5);
            logic [3:0] hex_nib;
            logic [3:0] dec_nib;

            if (gi < 4) begin : g_hex
                assign hex_nib = seg_data[gi*4 +: 4];
            end else begin : g_hex_blank
                assign hex_nib = 4'h0;
            end

            if (gi < 5) begin : g_dec
                assign dec_nib = bcd_q_reg[gi*4 +: 4];
            end else begin : g_dec_blank
                assign dec_nib = 4'h0;
            end

            assign nib[gi]   = disp_mode ? dec_nib : hex_nib;
            assign shown[gi] = disp_mode ? DEC_SHOWN : HEX_SHOWN;

            if (gi == 0) begin : g_lsd
                assign lit[gi] = shown[gi];
            end else begin : g_upper
                assign lit[gi] = shown[gi] & (~blank_lz | nz_from[gi]);
            end
        end
    endgenerate

    // nz_from[i]: some digit at position i or above is non-zero.
    always_comb begin
        logic acc;
        acc     = 1'b0;
        nz_from = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            acc        = acc | (nib[i] != 4'h0);
            nz_from[i] = acc;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs, updated once per digit slot
    // ------------------------------------------------------------------
    logic [7:0] seg_en_reg;
    logic [7:0] seg_out_reg;
    logic [7:0] seg_en_next;
    logic [7:0] seg_out_next;

    assign seg_en_next  = 8'h01 << idx_next;
    assign seg_out_next = lit[idx_next] ? {1'b0, seg7(nib[idx_next])} : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_en_reg  <= 8'h00;
            seg_out_reg <= 8'h00;
        end else if (tick) begin
            seg_en_reg  <= seg_en_next;
            seg_out_reg <= seg_out_next;
        end
    end

    assign seg_en  = seg_en_reg;
    assign seg_out = seg_out_reg;
    assign busy    = busy_reg;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan: table of display vectors plus hand-written sequences for
// scan timing, conversion latency, mid-conversion overwrite and asynchronous reset.
module tb_seg_scan;

    localparam int SD = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] seg_data;
    logic        disp_mode;
    logic        blank_lz;
    logic [7:0]  seg_en;
    logic [7:0]  seg_out;
    logic        busy;

    int tests;
    int fails;

    seg_scan #(.SCAN_DIV(SD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_data  (seg_data),
        .disp_mode (disp_mode),
        .blank_lz  (blank_lz),
        .seg_en    (seg_en),
        .seg_out   (seg_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic        mode;
        logic        blz;
        logic [63:0] exp;   // digit i expected seg_out at [8i +: 8]
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Wait for a fresh digit-0 slot (seg_en goes 80 -> 01), bounded.
    task automatic sync_digit0(output bit ok);
        int n;
        n = 0;
        while (seg_en !== 8'h80 && n < 200) begin
            @(negedge clk);
            n++;
        end
        while (seg_en !== 8'h01 && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 200);
    endtask

    task automatic check_display(input vec_t v, input string tag);
        bit ok;
        logic [7:0] exp_en;
        sync_digit0(ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s sync: got seg_en %h expected 01 within 200 cycles", tag, seg_en);
        end else begin
            for (int d = 0; d < 8; d++) begin
                exp_en = 8'h01 << d;
                chk($sformatf("%s en%0d", tag, d), seg_en, exp_en);
                chk($sformatf("%s seg%0d", tag, d), seg_out, v.exp[d*8 +: 8]);
                repeat (SD) @(negedge clk);
            end
        end
        $display("[TB] %s data=%h mode=%0d blz=%0d checked", tag, v.data, v.mode, v.blz);
    endtask

    initial begin
        int slot;
        logic [7:0] exp_en;
        logic [7:0] exp_out;
        logic exp_busy;
        vec_t v;

        tests = 0;
        fails = 0;

        vecs[0]  = '{16'h0000, 1'b0, 1'b0, 64'h00000000_3F3F3F3F};
        vecs[1]  = '{16'h1A3F, 1'b0, 1'b0, 64'h00000000_06774F71};
        vecs[2]  = '{16'h0005, 1'b0, 1'b1, 64'h00000000_0000006D};
        vecs[3]  = '{16'h0000, 1'b0, 1'b1, 64'h00000000_0000003F};
        vecs[4]  = '{16'h0B0C, 1'b0, 1'b1, 64'h00000000_007C3F39};
        vecs[5]  = '{16'h8E2D, 1'b0, 1'b0, 64'h00000000_7F795B5E};
        vecs[6]  = '{16'd65535, 1'b1, 1'b0, 64'h0000007D_6D6D4F6D};
        vecs[7]  = '{16'd100,   1'b1, 1'b1, 64'h00000000_00063F3F};
        vecs[8]  = '{16'd7,     1'b1, 1'b1, 64'h00000000_00000007};
        vecs[9]  = '{16'd1234,  1'b1, 1'b0, 64'h0000003F_065B4F66};
        vecs[10] = '{16'd40960, 1'b1, 1'b1, 64'h00000066_3F6F7D3F};
        vecs[11] = '{16'd0,     1'b1, 1'b0, 64'h0000003F_3F3F3F3F};

        // Reset state
        seg_data  = 16'h0;
        disp_mode = 1'b0;
        blank_lz  = 1'b0;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;
        #1;
        chk("rst seg_en", seg_en, 8'h00);
        chk("rst seg_out", seg_out, 8'h00);
        chk("rst busy", {7'h0, busy}, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Scan timing from reset: first tick on the SD-th edge shows digit 1
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            slot    = e / SD;
            exp_en  = (slot == 0) ? 8'h00 : (8'h01 << (slot % 8));
            exp_out = (slot == 0) ? 8'h00 : (((slot % 8) < 4) ? 8'h3F : 8'h00);
            chk($sformatf("scan en e%0d", e), seg_en, exp_en);
            chk($sformatf("scan seg e%0d", e), seg_out, exp_out);
            chk($sformatf("scan busy e%0d", e), {7'h0, busy}, 8'h00);
        end
        $display("[TB] scan timing sequence checked");

        // Conversion latency: 0 -> 65535 launched after edge N
        disp_mode = 1'b1;
        @(posedge clk);
        #1 seg_data = 16'd65535;
        for (int k = 1; k <= 22; k++) begin
            @(posedge clk);
            #1;
            exp_busy = (k >= 2 && k <= 18);
            chk($sformatf("conv busy k%0d", k), {7'h0, busy}, {7'h0, exp_busy});
        end
        check_display(vecs[6], "conv65535");

        // Overwrite during SHIFT: 100 finishes first, then 7 converts
        blank_lz = 1'b1;
        @(posedge clk);
        #1 seg_data = 16'd100;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 5) seg_data = 16'd7;
            exp_busy = (k >= 2 && k <= 18) || (k >= 21 && k <= 37);
            chk($sformatf("ovr busy k%0d", k), {7'h0, busy}, {7'h0, exp_busy});
        end
        check_display(vecs[8], "ovr7");

        // Table-driven display vectors
        for (int i = 0; i < 12; i++) begin
            v = vecs[i];
            @(negedge clk);
            seg_data  = v.data;
            disp_mode = v.mode;
            blank_lz  = v.blz;
            repeat (40) @(negedge clk);
            check_display(v, $sformatf("vec%0d", i));
        end

        // Asynchronous reset in the middle of a conversion
        disp_mode = 1'b1;
        blank_lz  = 1'b0;
        @(posedge clk);
        #1 seg_data = 16'd4321;
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst seg_en", seg_en, 8'h00);
        chk("midrst seg_out", seg_out, 8'h00);
        chk("midrst busy", {7'h0, busy}, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        chk("relrst busy", {7'h0, busy}, 8'h00);
        @(posedge clk);
        #1 chk("relrst busy e1", {7'h0, busy}, 8'h00);
        @(posedge clk);
        #1 chk("relrst busy e2", {7'h0, busy}, 8'h01);
        repeat (40) @(negedge clk);
        v = '{16'd4321, 1'b1, 1'b0, 64'h0000003F_664F5B06};
        check_display(v, "rst4321");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
